// File: rtl/fifo_rd_arbiter.sv
// Read-side round-robin, burst-limited scheduler for the async FIFO.
// Pops are returned one cycle later, tagged with the owning requester ID.
module fifo_rd_arbiter #(
  parameter int N_REQ  = 4,
  parameter int BURST  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              rempty,
  input  logic [DATA_W-1:0] rdata,
  output logic              rinc,
  output logic [N_REQ-1:0]  gnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_id,
  output logic              busy
);

  localparam int BC_W = $clog2(BURST) + 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST - 1);
  localparam logic [ID_W-1:0] LP_RST = ID_W'(N_REQ - 1);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t state, state_n;

  logic [N_REQ-1:0] gnt_n;
  logic [ID_W-1:0]  lp, lp_n;
  logic [ID_W-1:0]  pick, cid;
  logic [BC_W-1:0]  bc, bc_n;
  logic             found;
  logic             last_pop;
  int               cand;

  // Search starts just past the last winner so it gets lowest priority.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    cid   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(lp) + k) % N_REQ;
      cid  = ID_W'(cand);
      if (!found && req[cid]) begin
        found = 1'b1;
        pick  = cid;
      end
    end
  end

  assign last_pop = (bc == BC_LAST);

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    lp_n    = lp;
    bc_n    = bc;
    rinc    = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_n = '0;
        if (found && !rempty) begin
          state_n = XFER;
          gnt_n   = N_REQ'(1) << pick;
          lp_n    = pick;
          bc_n    = '0;
        end
      end
      XFER: begin
        rinc = req[lp] & ~rempty;
        if (!req[lp]) begin
          state_n = IDLE;
          gnt_n   = '0;
        end else if (rinc) begin
          bc_n = bc + BC_W'(1);
          if (last_pop) begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      lp        <= LP_RST;
      bc        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      lp        <= lp_n;
      bc        <= bc_n;
      out_valid <= rinc;
      if (rinc) begin
        out_data <= rdata;
        out_id   <= lp;
      end
    end
  end

  assign busy = (state == XFER);

  a_no_underflow: assert property (
    @(posedge rclk) disable iff (!rrst_n) !(rinc && rempty));

  a_gnt_onehot: assert property (
    @(posedge rclk) disable iff (!rrst_n) $onehot0(gnt));

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: cycle tables plus a FIFO model and
// a scoreboard of expected {data, id} returns.
module tb_fifo_rd_arbiter;

  logic       rclk   = 1'b0;
  logic       rrst_n = 1'b1;
  logic [3:0] req    = '0;
  logic       rempty = 1'b1;
  logic [7:0] rdata  = '0;
  logic       rinc;
  logic [3:0] gnt;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_id;
  logic       busy;

  fifo_rd_arbiter #(
    .N_REQ (4),
    .BURST (4),
    .DATA_W(8)
  ) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .req      (req),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .gnt      (gnt),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
    .busy     (busy)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rinc;
    logic       wr;
    logic [1:0] wid;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;

  vec_t       tab[$];
  exp_t       sb[$];
  logic [7:0] fq[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g,
                              input logic i, input logic w = 1'b0,
                              input logic [1:0] id = 2'd0);
    vec_t v;
    v.req  = r;
    v.gnt  = g;
    v.rinc = i;
    v.wr   = w;
    v.wid  = id;
    return v;
  endfunction

  task automatic put(input logic [1:0] id, input bit keep);
    logic [7:0] d;
    exp_t       e;
    d = 8'($urandom_range(0, 255));
    fq.push_back(d);
    if (keep) begin
      e.data = d;
      e.id   = id;
      sb.push_back(e);
    end
  endtask

  task automatic load(input int n, input logic [1:0] id, input bit keep);
    for (int i = 0; i < n; i++) put(id, keep);
  endtask

  task automatic drive_fifo();
    rempty = (fq.size() == 0);
    rdata  = rempty ? 8'h00 : fq[0];
  endtask

  task automatic tick(input vec_t v, input string nm);
    exp_t e;
    logic p;
    @(negedge rclk);
    if (v.wr) put(v.wid, 1'b1);
    req = v.req;
    drive_fifo();
    #1;
    chk({nm, "_gnt"}, 32'(gnt), 32'(v.gnt));
    chk({nm, "_rinc"}, 32'(rinc), 32'(v.rinc));
    chk({nm, "_busy"}, 32'(busy), 32'(v.gnt != 4'b0));
    chk({nm, "_underflow"}, 32'(rinc & rempty), 32'(0));
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_extra: out_valid=1 with none expected", nm);
      end else begin
        e = sb.pop_front();
        chk({nm, "_data"}, 32'(out_data), 32'(e.data));
        chk({nm, "_id"}, 32'(out_id), 32'(e.id));
      end
    end
    p = rinc;
    @(posedge rclk);
    if (p && fq.size() != 0) void'(fq.pop_front());
  endtask

  task automatic run(input string nm);
    foreach (tab[i]) tick(tab[i], $sformatf("%s[%0d]", nm, i));
    tab.delete();
    chk({nm, "_drain"}, 32'(sb.size()), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n = 1'b0;
    req    = '0;
    drive_fifo();
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_data", 32'(out_data), 32'(0));
    chk("rst_id", 32'(out_id), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rinc", 32'(rinc), 32'(0));
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] g;
    #1 rrst_n = 1'b0;
    do_reset();

    // empty FIFO: requests are never granted
    for (int i = 0; i < 10; i++) tab.push_back(mk(4'b1111, 4'b0, 1'b0));
    run("empty");

    // single requester 2, three words, then stall, then release
    load(3, 2'd2, 1'b1);
    tab.push_back(mk(4'b0100, 4'b0000, 1'b0));
    tab.push_back(mk(4'b0100, 4'b0100, 1'b1));
    tab.push_back(mk(4'b0100, 4'b0100, 1'b1));
    tab.push_back(mk(4'b0100, 4'b0100, 1'b1));
    tab.push_back(mk(4'b0100, 4'b0100, 1'b0));
    tab.push_back(mk(4'b0100, 4'b0100, 1'b0));
    tab.push_back(mk(4'b0000, 4'b0100, 1'b0));
    tab.push_back(mk(4'b0000, 4'b0000, 1'b0));
    run("req2");

    // requester 1: two pops, five stalls, late third word
    load(2, 2'd1, 1'b1);
    tab.push_back(mk(4'b0010, 4'b0000, 1'b0));
    tab.push_back(mk(4'b0010, 4'b0010, 1'b1));
    tab.push_back(mk(4'b0010, 4'b0010, 1'b1));
    for (int i = 0; i < 5; i++) tab.push_back(mk(4'b0010, 4'b0010, 1'b0));
    tab.push_back(mk(4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1));
    tab.push_back(mk(4'b0010, 4'b0010, 1'b0));
    tab.push_back(mk(4'b0000, 4'b0010, 1'b0));
    tab.push_back(mk(4'b0000, 4'b0000, 1'b0));
    run("stall");

    // all requesting, 16 words: bursts of 4 with one bubble each
    do_reset();
    for (int r = 0; r < 4; r++) load(4, 2'(r), 1'b1);
    for (int c = 0; c < 22; c++) begin
      if (c == 0 || (c - 1) % 5 == 4 || (c - 1) / 5 > 3) g = 4'b0;
      else g = 4'(1 << ((c - 1) / 5));
      tab.push_back(mk(4'b1111, g, g != 4'b0));
    end
    tab.push_back(mk(4'b0000, 4'b0000, 1'b0));
    run("rr");

    // requester 3 releases after two pops; wrap grants 0 next
    load(2, 2'd3, 1'b1);
    load(2, 2'd0, 1'b1);
    tab.push_back(mk(4'b1000, 4'b0000, 1'b0));
    tab.push_back(mk(4'b1000, 4'b1000, 1'b1));
    tab.push_back(mk(4'b1000, 4'b1000, 1'b1));
    tab.push_back(mk(4'b0000, 4'b1000, 1'b0));
    tab.push_back(mk(4'b1001, 4'b0000, 1'b0));
    tab.push_back(mk(4'b1001, 4'b0001, 1'b1));
    tab.push_back(mk(4'b1001, 4'b0001, 1'b1));
    tab.push_back(mk(4'b1001, 4'b0001, 1'b0));
    tab.push_back(mk(4'b0000, 4'b0001, 1'b0));
    tab.push_back(mk(4'b0000, 4'b0000, 1'b0));
    run("release");

    // reset mid-burst: second word's out_valid is lost
    put(2'd1, 1'b1);
    put(2'd1, 1'b0);
    load(4, 2'd0, 1'b1);
    load(2, 2'd1, 1'b1);
    tab.push_back(mk(4'b1111, 4'b0000, 1'b0));
    tab.push_back(mk(4'b1111, 4'b0010, 1'b1));
    tab.push_back(mk(4'b1111, 4'b0010, 1'b1));
    foreach (tab[i]) tick(tab[i], $sformatf("pre_rst[%0d]", i));
    tab.delete();
    @(negedge rclk);
    rrst_n = 1'b0;
    drive_fifo();
    #1;
    chk("midrst_gnt", 32'(gnt), 32'(0));
    chk("midrst_valid", 32'(out_valid), 32'(0));
    chk("midrst_rinc", 32'(rinc), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    @(negedge rclk);
    #1;
    chk("rst_hold_rinc", 32'(rinc), 32'(0));
    chk("rst_hold_gnt", 32'(gnt), 32'(0));
    req    = '0;
    rrst_n = 1'b1;
    tab.push_back(mk(4'b1111, 4'b0000, 1'b0));
    for (int i = 0; i < 4; i++) tab.push_back(mk(4'b1111, 4'b0001, 1'b1));
    tab.push_back(mk(4'b1111, 4'b0000, 1'b0));
    tab.push_back(mk(4'b1111, 4'b0010, 1'b1));
    tab.push_back(mk(4'b1111, 4'b0010, 1'b1));
    tab.push_back(mk(4'b1111, 4'b0010, 1'b0));
    tab.push_back(mk(4'b0000, 4'b0010, 1'b0));
    tab.push_back(mk(4'b0000, 4'b0000, 1'b0));
    run("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
